// File: rtl/sprite_palette_bank_if.sv
// Sprite palette bank bus.
// Carries the frame/bank controls, the palette write port and the pixel lookup stream
// between a sprite index source (master) and the palette (slave).
//   master drives : frame_start, bank_sel, flash_en, flash_bank, wr_en, wr_bank, wr_index,
//                   wr_data, pix_valid_in, pix_index
//   slave drives  : pix_valid_out, red, green, blue, transparent, active_bank
interface sprite_palette_bank_if #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned COLOR_W = 4,
  parameter int unsigned BANK_W  = 2
);
  logic                 frame_start;
  logic [BANK_W-1:0]    bank_sel;
  logic                 flash_en;
  logic [BANK_W-1:0]    flash_bank;
  logic                 wr_en;
  logic [BANK_W-1:0]    wr_bank;
  logic [INDEX_W-1:0]   wr_index;
  logic [3*COLOR_W-1:0] wr_data;
  logic                 pix_valid_in;
  logic [INDEX_W-1:0]   pix_index;
  logic                 pix_valid_out;
  logic [COLOR_W-1:0]   red;
  logic [COLOR_W-1:0]   green;
  logic [COLOR_W-1:0]   blue;
  logic                 transparent;
  logic [BANK_W-1:0]    active_bank;

  modport master (
    output frame_start, bank_sel, flash_en, flash_bank,
    output wr_en, wr_bank, wr_index, wr_data,
    output pix_valid_in, pix_index,
    input  pix_valid_out, red, green, blue, transparent, active_bank
  );

  modport slave (
    input  frame_start, bank_sel, flash_en, flash_bank,
    input  wr_en, wr_bank, wr_index, wr_data,
    input  pix_valid_in, pix_index,
    output pix_valid_out, red, green, blue, transparent, active_bank
  );
endinterface

// File: rtl/sprite_palette_bank.sv
// Multi-bank writable sprite colour palette.
// Maps a per-pixel colour index to a registered {R,G,B} value (latency 1) from the bank that
// is currently active, with an optional transparency flag. The active bank only changes on a
// frame_start pulse, optionally alternating between bank_sel and flash_bank every
// FLASH_PERIOD frames for hit-flash effects.
// Ports:
//   Clk      - pixel clock, rising edge
//   Reset_n  - asynchronous active-low reset; clears palette, outputs and bank state
//   bus      - sprite_palette_bank_if slave: controls, write port, pixel in/out stream
module sprite_palette_bank #(
  parameter int unsigned INDEX_W      = 4,
  parameter int unsigned COLOR_W      = 4,
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned FLASH_PERIOD = 8,
  parameter bit          TRANSP_EN    = 1'b1,
  parameter int unsigned TRANSP_INDEX = 0
) (
  input logic                  Clk,
  input logic                  Reset_n,
  sprite_palette_bank_if.slave bus
);

  localparam int unsigned BANK_W = $clog2(NUM_BANKS);
  localparam int unsigned DEPTH  = 2 ** INDEX_W;
  localparam int unsigned RGB_W  = 3 * COLOR_W;
  localparam int unsigned CNT_W  = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  localparam logic [CNT_W-1:0]   CntLast     = CNT_W'(FLASH_PERIOD - 1);
  localparam logic [INDEX_W-1:0] TranspIndex = INDEX_W'(TRANSP_INDEX);

  typedef enum logic {
    PhBase,
    PhFlash
  } phase_e;

  // --------------------------------------------------------------------------
  // Palette storage: resettable flops, so no RAM inference.
  // --------------------------------------------------------------------------
  logic [RGB_W-1:0] pal_q [NUM_BANKS][DEPTH];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        for (int e = 0; e < int'(DEPTH); e++) begin
          pal_q[b][e] <= '0;
        end
      end
    end else if (bus.wr_en) begin
      pal_q[bus.wr_bank][bus.wr_index] <= bus.wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Bank / flash FSM. Only frame_start advances it, so a frame never tears.
  // --------------------------------------------------------------------------
  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BANK_W-1:0]  active_bank_q, active_bank_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_q       <= PhBase;
      cnt_q         <= '0;
      active_bank_q <= '0;
    end else begin
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      active_bank_q <= active_bank_d;
    end
  end

  always_comb begin
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    active_bank_d = active_bank_q;
    if (bus.frame_start) begin
      if (!bus.flash_en) begin
        phase_d = PhBase;
        cnt_d   = '0;
      end else if (cnt_q == CntLast) begin
        cnt_d = '0;
        unique case (phase_q)
          PhBase:  phase_d = PhFlash;
          PhFlash: phase_d = PhBase;
          default: phase_d = PhBase;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Re-sample the bank inputs for the (possibly new) phase on every pulse.
      active_bank_d = (phase_d == PhFlash) ? bus.flash_bank : bus.bank_sel;
    end
  end

  // --------------------------------------------------------------------------
  // Lookup pipeline. Reads use active_bank_q and pal_q before this edge's updates, which gives
  // pre-update bank on a frame_start cycle and read-before-write on a colliding write.
  // --------------------------------------------------------------------------
  logic             valid_q, valid_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             transp_q, transp_d;

  always_comb begin
    valid_d  = bus.pix_valid_in;
    rgb_d    = '0;
    transp_d = 1'b0;
    if (bus.pix_valid_in) begin
      rgb_d    = pal_q[active_bank_q][bus.pix_index];
      transp_d = TRANSP_EN && (bus.pix_index == TranspIndex);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q  <= 1'b0;
      rgb_q    <= '0;
      transp_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      rgb_q    <= rgb_d;
      transp_q <= transp_d;
    end
  end

  assign bus.pix_valid_out = valid_q;
  assign bus.red           = rgb_q[RGB_W-1 -: COLOR_W];
  assign bus.green         = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign bus.blue          = rgb_q[COLOR_W-1:0];
  assign bus.transparent   = transp_q;
  assign bus.active_bank   = active_bank_q;

endmodule
